// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: immediate formats, bubble instruction
// and the RISC-V register-field bit positions.
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    // addi x0,x0,0 -- the canonical bubble
    localparam logic [31:0] NOP_INSTR_RV = 32'h0000_0013;

    // Register fields are always 5 bits wide in the encoding
    localparam int FIELD_W = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

endpackage

// File: rtl/decode_stage_p_regfile.sv
// Register file with x0 hardwired to zero, write-first read bypass and a
// non-bypassed tap of x10 for test visibility.
module regfile_p #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    output logic [DATA_WIDTH-1:0] a0_o
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic                  wr_en;

    // x0 is never written, so its reset value of zero persists
    assign wr_en = we_i && (waddr_i != '0);

    // Next-state of the register array: one writeback port
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads: a writeback to the same register this cycle is forwarded
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (wr_en && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    end

    assign a0_o = regs_q[10];

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: IF/ID pipeline register, register file and immediate
// extension. Operands and immediate are combinational from IF/ID.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_RV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallD_i,
    input  logic                  FlushD_i,
    input  logic [31:0]           InstrF_i,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4F_i,
    input  logic [2:0]            ImmSrcD_i,
    input  logic                  RegWriteW_i,
    input  logic [ADDR_WIDTH-1:0] RdW_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    output logic [31:0]           InstrD_o,
    output logic                  ValidD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic [ADDR_WIDTH-1:0] Rs1D_o,
    output logic [ADDR_WIDTH-1:0] Rs2D_o,
    output logic [ADDR_WIDTH-1:0] RdD_o,
    output logic                  IllegalRegD_o,
    output logic [DATA_WIDTH-1:0] RD1D_o,
    output logic [DATA_WIDTH-1:0] RD2D_o,
    output logic [DATA_WIDTH-1:0] ImmExtD_o,
    output logic [DATA_WIDTH-1:0] a0_o
);
    logic [31:0]           instr_q,   instr_d;
    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] pc_q,      pc_d;
    logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic signed [31:0]    imm32;

    // Sign-extend a 32-bit immediate to the datapath width
    function automatic logic [DATA_WIDTH-1:0] sext32(input logic signed [31:0] v);
        logic signed [DATA_WIDTH-1:0] w;
        w = DATA_WIDTH'(v);
        return w;
    endfunction

    // IF/ID next state: flush beats stall beats load
    always_comb begin
        instr_d   = instr_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        if (FlushD_i) begin
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            pc_d      = '0;
            pcplus4_d = '0;
        end else if (!StallD_i) begin
            instr_d   = InstrF_i;
            valid_d   = 1'b1;
            pc_d      = PCF_i;
            pcplus4_d = PCPlus4F_i;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            pcplus4_q <= '0;
        end else begin
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign InstrD_o   = instr_q;
    assign ValidD_o   = valid_q;
    assign PCD_o      = pc_q;
    assign PCPlus4D_o = pcplus4_q;

    // Indices are truncated for narrow register files; the dropped top bit
    // is what flags an out-of-range reference
    assign Rs1D_o = instr_q[RS1_LSB +: ADDR_WIDTH];
    assign Rs2D_o = instr_q[RS2_LSB +: ADDR_WIDTH];
    assign RdD_o  = instr_q[RD_LSB  +: ADDR_WIDTH];

    assign IllegalRegD_o = (ADDR_WIDTH < FIELD_W) && valid_q &&
                           (instr_q[RD_LSB  + FIELD_W - 1] ||
                            instr_q[RS1_LSB + FIELD_W - 1] ||
                            instr_q[RS2_LSB + FIELD_W - 1]);

    // Immediate assembly; every format takes its sign from instr[31]
    always_comb begin
        imm32 = '0;
        case (imm_src_e'(ImmSrcD_i))
            IMM_I:   imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S:   imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B:   imm32 = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                              instr_q[11:8], 1'b0};
            IMM_U:   imm32 = {instr_q[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                              instr_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign ImmExtD_o = sext32(imm32);

    regfile_p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (RegWriteW_i),
        .waddr_i  (RdW_i),
        .wdata_i  (ResultW_i),
        .raddr1_i (Rs1D_o),
        .raddr2_i (Rs2D_o),
        .rdata1_o (RD1D_o),
        .rdata2_o (RD2D_o),
        .a0_o     (a0_o)
    );

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: an RV32I instance and an RV32E
// instance share all stimulus.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, regwrite;
    logic [31:0] instrf, pcf, pcp4f, resultw;
    logic [2:0]  immsrc;
    logic [4:0]  rdw;

    logic [31:0] instrd, pcd, pcp4d, rd1, rd2, imm, a0;
    logic        validd, illegal;
    logic [4:0]  rs1, rs2, rd;

    logic [31:0] e_instrd, e_pcd, e_pcp4d, e_rd1, e_rd2, e_imm, e_a0;
    logic        e_validd, e_illegal;
    logic [3:0]  e_rs1, e_rs2, e_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage_p #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .StallD_i(stall), .FlushD_i(flush),
        .InstrF_i(instrf), .PCF_i(pcf), .PCPlus4F_i(pcp4f), .ImmSrcD_i(immsrc),
        .RegWriteW_i(regwrite), .RdW_i(rdw), .ResultW_i(resultw),
        .InstrD_o(instrd), .ValidD_o(validd), .PCD_o(pcd), .PCPlus4D_o(pcp4d),
        .Rs1D_o(rs1), .Rs2D_o(rs2), .RdD_o(rd), .IllegalRegD_o(illegal),
        .RD1D_o(rd1), .RD2D_o(rd2), .ImmExtD_o(imm), .a0_o(a0)
    );

    decode_stage_p #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut_e (
        .clk(clk), .rst_n(rst_n), .StallD_i(stall), .FlushD_i(flush),
        .InstrF_i(instrf), .PCF_i(pcf), .PCPlus4F_i(pcp4f), .ImmSrcD_i(immsrc),
        .RegWriteW_i(regwrite), .RdW_i(rdw[3:0]), .ResultW_i(resultw),
        .InstrD_o(e_instrd), .ValidD_o(e_validd), .PCD_o(e_pcd), .PCPlus4D_o(e_pcp4d),
        .Rs1D_o(e_rs1), .Rs2D_o(e_rs2), .RdD_o(e_rd), .IllegalRegD_o(e_illegal),
        .RD1D_o(e_rd1), .RD2D_o(e_rd2), .ImmExtD_o(e_imm), .a0_o(e_a0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving a margin before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] pc);
        instrf = ins; pcf = pc; pcp4f = pc + 32'd4;
        stall = 1'b0; flush = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; regwrite = 1'b0;
        instrf = 32'h0; pcf = 32'h0; pcp4f = 32'h0; resultw = 32'h0;
        immsrc = 3'b000; rdw = 5'd0;

        // Reset held while inputs move
        for (int i = 0; i < 4; i++) begin
            instrf = 32'hA5A5_0000 + i; pcf = 32'h40 * i; regwrite = 1'b1;
            rdw = 5'd10; resultw = 32'h1111_0000 + i;
            tick();
        end
        regwrite = 1'b0;
        chk("rst_instr", instrd, 32'h0000_0013);
        chk("rst_valid", {31'b0, validd}, 32'd0);
        chk("rst_pcd",   pcd, 32'd0);
        chk("rst_a0",    a0, 32'd0);
        #2 rst_n = 1'b1;

        // First load after reset
        load(32'hFFF0_0093, 32'h100);
        chk("ld_valid", {31'b0, validd}, 32'd1);
        chk("ld_pcd",   pcd, 32'h100);
        chk("ld_pcp4",  pcp4d, 32'h104);
        chk("ld_rs1",   {27'b0, rs1}, 32'd0);
        chk("ld_rd",    {27'b0, rd}, 32'd1);
        chk("ld_imm_i", imm, 32'hFFFF_FFFF);

        // Stall holds, flush overrides stall
        load(32'h0080_00EF, 32'h200);
        stall = 1'b1; instrf = 32'h1234_5678; pcf = 32'h300; immsrc = 3'b100;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_instr", instrd, 32'h0080_00EF);
        chk("stall_pcd",   pcd, 32'h200);
        chk("imm_j",       imm, 32'h0000_0008);
        flush = 1'b1;
        tick();
        chk("flush_instr", instrd, 32'h0000_0013);
        chk("flush_valid", {31'b0, validd}, 32'd0);
        chk("flush_pcd",   pcd, 32'd0);

        // Writeback bypass into rs1=x10 (addi x11,x10,0)
        load(32'h0005_0593, 32'h400);
        stall = 1'b1;
        regwrite = 1'b1; rdw = 5'd10; resultw = 32'hDEAD_BEEF;
        #1;
        chk("byp_rd1", rd1, 32'hDEAD_BEEF);
        chk("byp_a0_pre", a0, 32'd0);
        tick();
        regwrite = 1'b0;
        #1;
        chk("wb_a0",  a0, 32'hDEAD_BEEF);
        chk("wb_rd1", rd1, 32'hDEAD_BEEF);
        // x0 write is discarded; rs2 of this instruction is x0
        regwrite = 1'b1; rdw = 5'd0; resultw = 32'h5;
        #1;
        chk("x0_byp", rd2, 32'd0);
        tick();
        regwrite = 1'b0;
        #1;
        chk("x0_rd", rd2, 32'd0);

        // Immediate formats
        immsrc = 3'b001; load(32'hFE11_2E23, 32'h500);
        chk("imm_s", imm, 32'hFFFF_FFFC);
        immsrc = 3'b010; load(32'hFE00_0EE3, 32'h504);
        chk("imm_b", imm, 32'hFFFF_FFFC);
        immsrc = 3'b011; load(32'h1234_50B7, 32'h508);
        chk("imm_u", imm, 32'h1234_5000);
        immsrc = 3'b111;
        #1;
        chk("imm_111", imm, 32'd0);
        immsrc = 3'b000;

        // RV32E register-range check
        load(32'h0110_0893, 32'h600);
        chk("e_illegal_x17", {31'b0, e_illegal}, 32'd1);
        chk("e_rd_trunc",    {28'b0, e_rd}, 32'd1);
        chk("i_illegal_x17", {31'b0, illegal}, 32'd0);
        load(32'h00F0_0793, 32'h604);
        chk("e_illegal_x15", {31'b0, e_illegal}, 32'd0);
        load(32'h0110_0893, 32'h608);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("e_illegal_flush", {31'b0, e_illegal}, 32'd0);

        // Async reset between edges after writing x5 (addi x10,x5,0)
        load(32'h0002_8513, 32'h700);
        stall = 1'b1; regwrite = 1'b1; rdw = 5'd5; resultw = 32'h0000_0055;
        tick();
        regwrite = 1'b0;
        #1;
        chk("x5_rd1", rd1, 32'h0000_0055);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd1",   rd1, 32'd0);
        chk("arst_instr", instrd, 32'h0000_0013);
        chk("arst_valid", {31'b0, validd}, 32'd0);
        chk("arst_a0",    a0, 32'd0);
        chk("arst_pcd",   pcd, 32'd0);
        #2 rst_n = 1'b1;
        load(32'h0002_8513, 32'h800);
        chk("post_rst_valid", {31'b0, validd}, 32'd1);
        chk("post_rst_pcd",   pcd, 32'h800);
        chk("post_rst_x5",    rd1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised successor to the pipeline decode stage. Owns the IF/ID pipeline register (stall/flush/valid), a register file with parametrised depth and same-cycle writeback bypass, and immediate extension. Sits between fetch and the ID/EX register. Supplies register operands, immediate, PC values and register indices to execute and the hazard unit.

Parameters:
DATA_WIDTH, 32, datapath/register width (>=32); immediates sign-extended to this width
ADDR_WIDTH, 5, register index width; 5 = 32 regs (RV32I), 4 = 16 regs (RV32E); legal range 4..5
NOP_INSTR, 32'h00000013, instruction loaded on flush/reset (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
StallD_i  in  1  hold IF/ID register
FlushD_i  in  1  replace IF/ID contents with bubble
InstrF_i  in  32  fetched instruction
PCF_i  in  DATA_WIDTH  fetch PC
PCPlus4F_i  in  DATA_WIDTH  fetch PC+4
ImmSrcD_i  in  3  immediate format from control unit
RegWriteW_i  in  1  writeback enable
RdW_i  in  ADDR_WIDTH  writeback destination
ResultW_i  in  DATA_WIDTH  writeback data
InstrD_o  out  32  registered instruction (to control unit)
ValidD_o  out  1  IF/ID holds a real instruction
PCD_o, PCPlus4D_o  out  DATA_WIDTH  registered PC, PC+4
Rs1D_o, Rs2D_o, RdD_o  out  ADDR_WIDTH  InstrD[19:15], [24:20], [11:7] truncated to ADDR_WIDTH
IllegalRegD_o  out  1  valid instr references a register index >= 2**ADDR_WIDTH
RD1D_o, RD2D_o  out  DATA_WIDTH  operands
ImmExtD_o  out  DATA_WIDTH  extended immediate
a0_o  out  DATA_WIDTH  current register x10 (test)

Behaviour:
- Reset (rst_n=0, async): InstrD=NOP_INSTR, ValidD=0, PCD=0, PCPlus4D=0, all registers 0; a0_o=0, RD1/RD2=0.
- IF/ID update on rising clk, priority: FlushD_i > StallD_i > load.
  - Flush: InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D=0. Flush with stall asserted: flush wins.
  - Stall: all IF/ID fields hold.
  - Load: InstrD<=InstrF_i, PCD<=PCF_i, PCPlus4D<=PCPlus4F_i, ValidD<=1.
- Latency: fetch inputs appear on D outputs one cycle after load edge; RD/Imm outputs combinational from IF/ID.
- Regfile write: on rising clk when RegWriteW_i=1 and RdW_i!=0; writes to x0 discarded; x0 reads 0 always. Writes independent of stall/flush.
- Read bypass: if RegWriteW_i && RdW_i==Rs1D && Rs1D!=0 then RD1D_o=ResultW_i same cycle, else stored value; identical for RD2. a0_o shows stored x10 (no bypass).
- IllegalRegD_o: ADDR_WIDTH=4 only; 1 when ValidD and bit4 of rd/rs1/rs2 field set (field used regardless of format); always 0 when ADDR_WIDTH=5. Truncated index still used for read.
- ImmSrcD_i: 000 I {instr[31:20]}; 001 S {[31:25],[11:7]}; 010 B {[31],[7],[30:25],[11:8],0}; 011 U {[31:12],12'b0}; 100 J {[31],[19:12],[20],[30:21],0}; sign-extended from bit 31 to DATA_WIDTH; 101-111 -> 0.
- Reset mid-stall/flush: reset wins asynchronously; first edge after release loads normally.

Decomposition:
- Package decode_pkg: imm_src_e enum (IMM_I..IMM_J), NOP_INSTR constant, instruction field bit-position localparams.
- Sub-module regfile_p (parametrised DATA_WIDTH/ADDR_WIDTH, async reset, x0 hardwired, write-first bypass, a0 tap). IF/ID register and extension stay in top.

Test Plan:
- Reset: hold rst_n=0 with toggling inputs -> InstrD=0x00000013, ValidD=0, PCD=0, a0_o=0; release, load InstrF=0xFFF00093, PCF=0x100 -> next cycle ValidD=1, PCD=0x100, Rs1D=0, RdD=1, ImmSrc=000 -> ImmExtD=0xFFFFFFFF.
- Stall/flush: load 0x008000EF at PC 0x200, then StallD=1 for 3 cycles with new InstrF -> InstrD holds 0x008000EF, ImmSrc=100 -> ImmExtD=0x00000008; assert Stall+Flush together -> InstrD=NOP, ValidD=0.
- Writeback/bypass: write x10=0xDEADBEEF while InstrD reads rs1=x10 -> RD1D=0xDEADBEEF same cycle, a0_o=0xDEADBEEF next cycle; write x0=0x5 -> reading x0 gives 0.
- Immediates: S instr 0xFE112E23 (sw x1,-4(x2)) ImmSrc=001 -> 0xFFFFFFFC; B 0xFE000EE3 ImmSrc=010 -> 0xFFFFFFFC; U 0x123450B7 ImmSrc=011 -> 0x12345000; ImmSrc=111 -> 0.
- RV32E (ADDR_WIDTH=4): load instr with rd=x17 (0x01100893) -> IllegalRegD=1, RdD=1; rd=x15 -> IllegalRegD=0; after flush IllegalRegD=0.
- Async reset mid-operation: assert rst_n low between clock edges after writing x5 -> registers and IF/ID clear immediately, without waiting for a clock edge.
